// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed big-endian byte stream into 32-bit imem words, holds the CPU in reset until done.
// Latency: imem_we 1 cycle after the 4th byte of a word; cpu_reset falls 2 cycles after the last byte.
// Backpressure: in_ready is registered from state, high only while header or data bytes are expected.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    FLUSH,
    DONE,
    ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [ADDR_W:0]   word_cnt;

  logic              accept;
  logic [15:0]       len_full;
  logic              word_fire;
  logic              last_word;

  assign accept    = in_valid && in_ready;
  assign len_full  = {len_hi, in_data};
  assign word_fire = (state == DATA) && accept && (byte_idx == 2'd3);
  // word_cnt is one bit wider than the address so LEN == DEPTH compares without wrapping
  assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, len};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= LEN_HI;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LEN_HI: begin
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0) begin
            state_nxt = FLUSH;
          end else if ({1'b0, len_full} > DEPTH) begin
            state_nxt = ERROR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (word_fire && last_word) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = LEN_HI;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_ready   <= 1'b1;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      in_ready   <= (state_nxt == LEN_HI) || (state_nxt == LEN_LO) || (state_nxt == DATA);
      cpu_reset  <= (state_nxt != DONE);
      load_done  <= (state_nxt == DONE);
      load_error <= (state_nxt == ERROR);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      len_hi   <= 8'd0;
      len      <= 16'd0;
      byte_idx <= 2'd0;
      word_buf <= 24'd0;
      word_cnt <= '0;
    end else begin
      if ((state == LEN_HI) && accept) begin
        len_hi <= in_data;
      end
      if ((state == LEN_LO) && accept) begin
        len <= len_full;
      end
      if ((state == DATA) && accept) begin
        byte_idx <= byte_idx + 2'd1;
        word_buf <= {word_buf[15:0], in_data};
      end
      if (word_fire) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= word_fire;
      if (word_fire) begin
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= {word_buf, in_data};
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/data streams, bubbles, mid-load reset, error and full-depth loads.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              Clk;
  logic              Reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    Reset = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!load_done && n < 20) begin
      tick();
      n++;
    end
    check("wait_done", 32'(load_done), 32'd1);
  endtask

  function automatic logic [31:0] wr_data(input int k);
    return (k < wd.size()) ? wd[k] : 32'hBAD0BAD0;
  endfunction

  function automatic logic [31:0] wr_addr(input int k);
    return (k < wa.size()) ? 32'(wa[k]) : 32'hBAD0BAD0;
  endfunction

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 8'h5A, b ^ 8'h3C};
  endfunction

  logic [7:0] t1_bytes[10];

  initial begin
    t1_bytes = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};

    // Reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);

    // T1: two words back-to-back, cycle-exact tail
    for (int i = 0; i < 10; i++) send(t1_bytes[i], 0);
    check("t1_flush_we", 32'(imem_we), 32'd1);
    check("t1_flush_addr", 32'(imem_addr), 32'd1);
    check("t1_flush_wdata", imem_wdata, 32'h01234567);
    check("t1_flush_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t1_flush_done", 32'(load_done), 32'd0);
    check("t1_flush_ready", 32'(in_ready), 32'd0);
    tick();
    check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t1_load_done", 32'(load_done), 32'd1);
    check("t1_we_off", 32'(imem_we), 32'd0);
    check("t1_addr_hold", 32'(imem_addr), 32'd1);
    check("t1_wdata_hold", imem_wdata, 32'h01234567);
    check("t1_nwr", 32'(wa.size()), 32'd2);
    check("t1_a0", wr_addr(0), 32'd0);
    check("t1_d0", wr_data(0), 32'hDEADBEEF);
    check("t1_a1", wr_addr(1), 32'd1);
    check("t1_d1", wr_data(1), 32'h01234567);

    // T2: zero-length image
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    check("t2_flush_ready", 32'(in_ready), 32'd0);
    check("t2_flush_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    check("t2_load_done", 32'(load_done), 32'd1);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t2_nwr", 32'(wa.size()), 32'd0);

    // T3: length 257 exceeds 256-word imem
    do_reset();
    send(8'h01, 0);
    send(8'h01, 0);
    tick();
    tick();
    check("t3_load_error", 32'(load_error), 32'd1);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t3_load_done", 32'(load_done), 32'd0);
    check("t3_nwr", 32'(wa.size()), 32'd0);

    // T4: T1 stream with random bubbles
    do_reset();
    for (int i = 0; i < 10; i++) send(t1_bytes[i], int'($urandom_range(0, 3)));
    wait_done();
    check("t4_nwr", 32'(wa.size()), 32'd2);
    check("t4_a0", wr_addr(0), 32'd0);
    check("t4_d0", wr_data(0), 32'hDEADBEEF);
    check("t4_a1", wr_addr(1), 32'd1);
    check("t4_d1", wr_data(1), 32'h01234567);

    // T5: reset mid-word, with a colliding byte offered during reset
    do_reset();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    in_valid = 1'b1;
    in_data  = 8'hCC;
    Reset    = 1'b1;
    tick();
    Reset    = 1'b0;
    in_valid = 1'b0;
    check("t5_rst_ready", 32'(in_ready), 32'd1);
    check("t5_rst_we", 32'(imem_we), 32'd0);
    check("t5_rst_nwr", 32'(wa.size()), 32'd0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    wait_done();
    check("t5_nwr", 32'(wa.size()), 32'd1);
    check("t5_a0", wr_addr(0), 32'd0);
    check("t5_d0", wr_data(0), 32'h11223344);

    // T6: traffic after DONE is ignored
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("t6_nwr", 32'(wa.size()), 32'd1);
    check("t6_addr", 32'(imem_addr), 32'd0);
    check("t6_wdata", imem_wdata, 32'h11223344);
    check("t6_done", 32'(load_done), 32'd1);
    check("t6_cpu_reset", 32'(cpu_reset), 32'd0);

    // LEN == DEPTH: fills every address with no wrap and no error
    do_reset();
    send(8'h01, 0);
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = pat(i);
      send(w[31:24], 0);
      send(w[23:16], 0);
      send(w[15:8], 0);
      send(w[7:0], 0);
    end
    wait_done();
    check("full_nwr", 32'(wa.size()), 32'd256);
    check("full_error", 32'(load_error), 32'd0);
    check("full_a0", wr_addr(0), 32'd0);
    check("full_d0", wr_data(0), 32'h00FF5A3C);
    check("full_a128", wr_addr(128), 32'd128);
    check("full_d128", wr_data(128), 32'h807F5ABC);
    check("full_a255", wr_addr(255), 32'd255);
    check("full_d255", wr_data(255), 32'hFF005AC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
